wishbone_master: RTL

Single-outstanding pipelined Wishbone B4 master. It accepts read/write commands on a valid/ready command port and drives one bus transaction per command, honouring `o_wb_stall`-style backpressure from the slave. It returns data and status on a valid/ready response port. It sits between the NES-side control logic (config/register sequencers) and the Wishbone register slaves, including slaves that acknowledge combinationally.

---
 rtl/wishbone_pkg.sv | 15 +
 rtl/wishbone_master_if.sv | 48 ++++
 rtl/wishbone_master_timeout_counter.sv | 29 ++
 rtl/wishbone_master.sv | 108 ++++++++++
 4 files changed

// File: rtl/wishbone_pkg.sv
// Shared Wishbone definitions: master state encoding and response status codes.
package wishbone_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } wb_state_t;

   localparam logic [1:0] WB_OK      = 2'd0;
   localparam logic [1:0] WB_BUSERR  = 2'd1;
   localparam logic [1:0] WB_TIMEOUT = 2'd2;

endpackage

// File: rtl/wishbone_master_if.sv
// Command, Wishbone bus and response signals of the single-outstanding master.
interface wishbone_master_if #(
   parameter int AW = 2,
   parameter int DW = 32
) ();

   logic              i_cmd_valid;
   logic              o_cmd_ready;
   logic              i_cmd_we;
   logic [AW-1:0]     i_cmd_addr;
   logic [DW-1:0]     i_cmd_data;
   logic [DW/8-1:0]   i_cmd_sel;

   logic              o_wb_cyc;
   logic              o_wb_stb;
   logic              o_wb_we;
   logic [AW-1:0]     o_wb_addr;
   logic [DW-1:0]     o_wb_odata;
   logic [DW/8-1:0]   o_wb_sel;
   logic              i_wb_ack;
   logic              i_wb_stall;
   logic              i_wb_err;
   logic [DW-1:0]     i_wb_idata;

   logic              o_rsp_valid;
   logic              i_rsp_ready;
   logic [DW-1:0]     o_rsp_data;
   logic [1:0]        o_rsp_status;

   modport master (
      input  i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_data, i_cmd_sel,
      input  i_wb_ack, i_wb_stall, i_wb_err, i_wb_idata,
      input  i_rsp_ready,
      output o_cmd_ready,
      output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_odata, o_wb_sel,
      output o_rsp_valid, o_rsp_data, o_rsp_status
   );

   modport slave (
      output i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_data, i_cmd_sel,
      output i_wb_ack, i_wb_stall, i_wb_err, i_wb_idata,
      output i_rsp_ready,
      input  o_cmd_ready,
      input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_odata, o_wb_sel,
      input  o_rsp_valid, o_rsp_data, o_rsp_status
   );

endinterface

// File: rtl/wishbone_master_timeout_counter.sv
// Counts cycles with cyc high; expire flags the last permitted cycle of a transaction.
module wb_timeout_counter #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   assign expire = (count == LAST);

endmodule

// File: rtl/wishbone_master.sv
// Single-outstanding pipelined Wishbone B4 master with stall handling and a per-transaction timeout.
module wishbone_master
   import wishbone_pkg::*;
#(
   parameter int AW      = 2,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input logic               i_clk,
   input logic               i_reset,
   wishbone_master_if.master bus
);

   wb_state_t       state;
   logic            accept;
   logic            accepted;
   logic            take_err;
   logic            take_ack;
   logic            time_out;
   logic            finish;
   logic            expire;
   logic [1:0]      fin_status;
   logic [DW-1:0]   fin_data;

   wb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk    (i_clk),
      .rst    (i_reset),
      .clear  (accept),
      .enable (bus.o_wb_cyc),
      .expire (expire)
   );

   // A slave response only counts once the request has been accepted (no stall);
   // err beats ack, and either beats the timeout.
   always_comb begin
      accept     = (state == ST_IDLE) && bus.o_cmd_ready && bus.i_cmd_valid;
      accepted   = ((state == ST_REQ) && !bus.i_wb_stall) || (state == ST_WAIT);
      take_err   = accepted && bus.i_wb_err;
      take_ack   = accepted && bus.i_wb_ack && !bus.i_wb_err;
      time_out   = ((state == ST_REQ) || (state == ST_WAIT)) && expire && !take_err && !take_ack;
      finish     = take_err || take_ack || time_out;
      fin_status = WB_OK;
      fin_data   = '0;
      if (take_err) begin
         fin_status = WB_BUSERR;
      end else if (time_out) begin
         fin_status = WB_TIMEOUT;
      end else if (take_ack && !bus.o_wb_we) begin
         fin_data = bus.i_wb_idata;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state            <= ST_IDLE;
         bus.o_cmd_ready  <= 1'b0;
         bus.o_wb_cyc     <= 1'b0;
         bus.o_wb_stb     <= 1'b0;
         bus.o_wb_we      <= 1'b0;
         bus.o_wb_addr    <= '0;
         bus.o_wb_odata   <= '0;
         bus.o_wb_sel     <= '0;
         bus.o_rsp_valid  <= 1'b0;
         bus.o_rsp_data   <= '0;
         bus.o_rsp_status <= WB_OK;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  bus.o_cmd_ready <= 1'b0;
                  bus.o_wb_cyc    <= 1'b1;
                  bus.o_wb_stb    <= 1'b1;
                  bus.o_wb_we     <= bus.i_cmd_we;
                  bus.o_wb_addr   <= bus.i_cmd_addr;
                  bus.o_wb_odata  <= bus.i_cmd_data;
                  bus.o_wb_sel    <= bus.i_cmd_sel;
                  state           <= ST_REQ;
               end else begin
                  bus.o_cmd_ready <= 1'b1;
               end
            end
            ST_REQ, ST_WAIT: begin
               if (finish) begin
                  bus.o_wb_cyc     <= 1'b0;
                  bus.o_wb_stb     <= 1'b0;
                  bus.o_rsp_valid  <= 1'b1;
                  bus.o_rsp_data   <= fin_data;
                  bus.o_rsp_status <= fin_status;
                  state            <= ST_RESP;
               end else if ((state == ST_REQ) && !bus.i_wb_stall) begin
                  bus.o_wb_stb <= 1'b0;
                  state        <= ST_WAIT;
               end
            end
            ST_RESP: begin
               // Ready is raised on the way out so the next command lands one cycle later.
               if (bus.i_rsp_ready) begin
                  bus.o_rsp_valid <= 1'b0;
                  bus.o_cmd_ready <= 1'b1;
                  state           <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
